// File: rtl/ahci_pkg.sv
// rtl/ahci_pkg.sv - shared state encoding and slot-count defaults for the AHCI command scheduler
package ahci_pkg;

  localparam int NUM_SLOTS_DEF = 32;
  localparam int SLOT_BITS_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFER  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/ahci_slot_prio_enc.sv
// rtl/ahci_slot_prio_enc.sv - rotate-and-priority-encode: first set mask bit at or after i_start, wrapping
module ahci_slot_prio_enc
  import ahci_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF
) (
  input  logic [NUM_SLOTS-1:0] i_mask,
  input  logic [SLOT_BITS-1:0] i_start,
  output logic                 o_found,
  output logic [SLOT_BITS-1:0] o_index
);

  logic [2*NUM_SLOTS-1:0] w_dbl;
  logic [NUM_SLOTS-1:0]   w_rot;
  logic [SLOT_BITS-1:0]   w_off;
  logic [SLOT_BITS:0]     w_sum;

  // Doubling the mask turns the wrap-around into a plain right shift.
  assign w_dbl = {i_mask, i_mask} >> i_start;
  assign w_rot = w_dbl[NUM_SLOTS-1:0];

  always_comb begin
    o_found = 1'b0;
    w_off   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_found = 1'b1;
        w_off   = SLOT_BITS'(i);
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, i_start} + {1'b0, w_off};
    if (w_sum >= (SLOT_BITS+1)'(NUM_SLOTS)) begin
      w_sum = w_sum - (SLOT_BITS+1)'(NUM_SLOTS);
    end
    o_index = w_sum[SLOT_BITS-1:0];
  end

endmodule

// File: rtl/ahci_cmd_slots.sv
// rtl/ahci_cmd_slots.sv - PxCI holder and single-active-command issue scheduler with error halt and abort
module ahci_cmd_slots
  import ahci_pkg::*;
#(
  parameter int NUM_SLOTS   = NUM_SLOTS_DEF,
  parameter int SLOT_BITS   = SLOT_BITS_DEF,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                 mclk,
  input  logic                 mrst,
  input  logic                 st_en,
  input  logic [NUM_SLOTS-1:0] ci_set,
  input  logic                 ci_clear_all,
  input  logic                 err_clear,
  output logic [NUM_SLOTS-1:0] ci,
  output logic [SLOT_BITS-1:0] ccs,
  output logic                 cmd_valid,
  output logic [SLOT_BITS-1:0] cmd_slot,
  input  logic                 cmd_ready,
  input  logic                 cmd_done,
  input  logic                 cmd_err,
  output logic                 cmd_abort,
  output logic                 busy,
  output logic                 halted,
  output logic                 ci_upd
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_SLOTS-1:0] r_ci;
  logic [SLOT_BITS-1:0] r_ccs;
  logic [SLOT_BITS-1:0] r_cmd_slot;
  logic                 r_ci_upd;
  logic                 r_cmd_abort;

  logic [NUM_SLOTS-1:0] w_ccs_onehot;
  logic [NUM_SLOTS-1:0] w_pending;
  logic [SLOT_BITS-1:0] w_start;
  logic                 w_found;
  logic [SLOT_BITS-1:0] w_idx;
  logic                 w_done_ok;

  assign w_ccs_onehot = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << r_ccs;
  assign w_pending    = r_ci & ~((r_state == ST_ACTIVE) ? w_ccs_onehot : '0);
  assign w_done_ok    = (r_state == ST_ACTIVE) && cmd_done && !cmd_err;

  always_comb begin
    w_start = '0;
    if (ROUND_ROBIN != 0) begin
      w_start = (r_ccs == SLOT_BITS'(NUM_SLOTS - 1)) ? '0 : r_ccs + SLOT_BITS'(1);
    end
  end

  ahci_slot_prio_enc #(
    .NUM_SLOTS(NUM_SLOTS),
    .SLOT_BITS(SLOT_BITS)
  ) u_prio (
    .i_mask (w_pending),
    .i_start(w_start),
    .o_found(w_found),
    .o_index(w_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (st_en && w_found) w_state_nxt = ST_OFFER;
      ST_OFFER: begin
        if (cmd_ready)   w_state_nxt = ST_ACTIVE;
        else if (!st_en) w_state_nxt = ST_IDLE;
      end
      ST_ACTIVE: if (cmd_done) w_state_nxt = cmd_err ? ST_HALT : ST_IDLE;
      ST_HALT:   if (err_clear) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (ci_clear_all) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge mclk) begin
    if (mrst) begin
      r_state     <= ST_IDLE;
      r_ci        <= '0;
      r_ccs       <= SLOT_BITS'(NUM_SLOTS - 1);
      r_cmd_slot  <= '0;
      r_ci_upd    <= 1'b0;
      r_cmd_abort <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ci_upd    <= w_done_ok && !ci_clear_all;
      r_cmd_abort <= ci_clear_all && (r_state == ST_ACTIVE);
      // A new set on the slot being completed wins over the clear.
      if (ci_clear_all) begin
        r_ci <= '0;
      end else begin
        r_ci <= (r_ci & ~(w_done_ok ? w_ccs_onehot : '0)) | ci_set;
      end
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_OFFER)) begin
        r_cmd_slot <= w_idx;
      end
      if ((r_state == ST_OFFER) && cmd_ready && !ci_clear_all) begin
        r_ccs <= r_cmd_slot;
      end
    end
  end

  assign ci        = r_ci;
  assign ccs       = r_ccs;
  assign cmd_valid = (r_state == ST_OFFER);
  assign cmd_slot  = r_cmd_slot;
  assign cmd_abort = r_cmd_abort;
  assign busy      = (r_state == ST_ACTIVE);
  assign halted    = (r_state == ST_HALT);
  assign ci_upd    = r_ci_upd;

endmodule

// File: doc/ahci_cmd_slots.md
Name: ahci_cmd_slots

Overview:
- Multi-slot command issue scheduler for the AHCI port: holds PxCI (NUM_SLOTS bits) and selects the next slot to issue.
- Offers the selected slot to the FIS transmit/DMA engine via a valid/ready handshake, tracks the one active command, and clears its PxCI bit on successful completion.
- Generalises the single-command path to NUM_SLOTS slots with selectable round-robin or lowest-index ordering, error halt and abort.
- Sits between axi_ahci_regs soft-write decode and ahci_fis_transmit/ahci_dma.

Parameters:
- NUM_SLOTS, 32, number of command slots (2..32).
- SLOT_BITS, 5, slot index width, must satisfy 2^SLOT_BITS >= NUM_SLOTS.
- ROUND_ROBIN, 1, 1 = search starts at the slot after the last issued one; 0 = lowest pending index always wins.

Ports:
- mclk  in  1  clock; single clock domain.
- mrst  in  1  synchronous reset, active high.
- st_en  in  1  PxCMD.ST level; 0 blocks issue.
- ci_set  in  NUM_SLOTS  one-cycle software write to PxCI: bits OR-ed into ci.
- ci_clear_all  in  1  pulse, ST 1->0 transition: clear all of PxCI and abort.
- err_clear  in  1  pulse: leave HALT after software error recovery.
- ci  out  NUM_SLOTS  current PxCI.
- ccs  out  SLOT_BITS  PxCMD.CCS: last issued slot.
- cmd_valid  out  1  slot offered to the engine.
- cmd_slot  out  SLOT_BITS  offered slot; stable while cmd_valid=1.
- cmd_ready  in  1  engine accepts the offered slot.
- cmd_done  in  1  pulse: active command finished.
- cmd_err  in  1  qualifies cmd_done: command failed.
- cmd_abort  out  1  pulse: abort the active command.
- busy  out  1  a command is active.
- halted  out  1  error halt.
- ci_upd  out  1  pulse: a PxCI bit was cleared by completion.

Behaviour:
- Reset: ci=0, ccs=NUM_SLOTS-1, cmd_valid=0, cmd_slot=0, cmd_abort=0, busy=0, halted=0, ci_upd=0, state=IDLE.
- Pending mask: ci, minus the active slot while ACTIVE.
- States and transitions:
  - IDLE: if st_en and ci!=0, register the selected slot into cmd_slot and go to OFFER. cmd_valid rises one cycle after the pending bit appears (selection is registered).
  - OFFER: cmd_valid=1. On cmd_ready, set ccs=cmd_slot, drop cmd_valid and go to ACTIVE with busy=1 in the next cycle. cmd_slot must not change while offering, even if a lower bit gets set.
  - ACTIVE: wait for cmd_done.
    - cmd_done with cmd_err=0: clear ci[ccs], pulse ci_upd, return to IDLE.
    - cmd_done with cmd_err=1: keep the bit, set halted, go to HALT.
  - HALT: no issue. err_clear returns to IDLE with halted=0, ci unchanged.
- Selection, ROUND_ROBIN=1: first set bit scanning from (ccs+1) mod NUM_SLOTS upward, wrapping at NUM_SLOTS-1 to 0.
- Selection, ROUND_ROBIN=0: lowest set bit.
- ci_clear_all, from any state: ci=0, cmd_valid=0, halted=0, next state IDLE. If the state was ACTIVE, pulse cmd_abort for one cycle. It has priority over everything else in the same cycle.
- st_en=0 in OFFER: withdraw cmd_valid and return to IDLE. ACTIVE is not affected.
- Simultaneous ci_set and completion of the same slot: the set wins, so the bit stays 1 (new command in the freed slot). ci_upd still pulses.
- ci_set bits for slots >= NUM_SLOTS do not exist. A ci_set on an already-set bit has no effect.
- cmd_done outside ACTIVE is ignored. cmd_ready outside OFFER is ignored.
- mrst mid-operation: everything returns to reset values next cycle; no cmd_abort pulse.

Decomposition:
- Shared package ahci_pkg: state encoding (IDLE, OFFER, ACTIVE, HALT) and the NUM_SLOTS/SLOT_BITS defaults.
- One sub-module, ahci_slot_prio_enc: combinational rotate-and-priority-encode. Inputs: mask, start index. Outputs: found, index. Instantiated once.
- The FSM and ci register live in the top.

Test Plan:
- Basic issue: reset, st_en=1, ci_set=0x00000004. Required: cmd_valid at +1 cycle with cmd_slot=2. Then cmd_ready -> busy=1, ccs=2. Then cmd_done, cmd_err=0 -> ci=0, one ci_upd pulse.
- Round-robin wrap: ROUND_ROBIN=1, ccs=30, ci=0x80000003. Required issue order 31, 0, 1.
- Lowest-index order: ROUND_ROBIN=0, same ci. Required order 0, 1, 31.
- Error halt: done with cmd_err=1 on slot 5. Required: halted=1, ci[5] stays 1, no cmd_valid while other bits are pending. err_clear -> slot 5 is re-offered.
- Abort: ACTIVE on slot 3 with ci=0x0000000C, pulse ci_clear_all. Required: one-cycle cmd_abort, ci=0, busy=0, no further offers.
- Set/clear collision: in the cmd_done cycle for slot 7, also ci_set=0x80. Required: ci[7]=1 afterwards, ci_upd=1, slot 7 re-offered.
